sha_msg_scheduler: RTL and testbench
====================================

Name: sha_msg_scheduler

Overview:
Message-schedule sequencer for the SHA-256 datapath. Accepts one 512-bit block and holds a 16-word sliding window. Drives the four operand taps of the extension stage (sha_extension, 1-cycle registered) and captures its result. Streams W[0..63] in order to the compression core over a valid/ready interface.

Parameters:
WORD_W, 32, word width; only 32 is supported.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
blk_valid  in  1  block offer
blk_ready  out  1  block accepted when blk_valid && blk_ready
blk_data  in  512  message block; W[i] = blk_data[511-32i -: 32] (big-endian)
flush  in  1  synchronous abort to IDLE
w_16, w_15, w_7, w_2  out  32 each  extension operand taps
ext_w  in  32  extension result, valid 1 cycle after taps stable
w_out  out  32  schedule word W[t]
w_idx  out  6  t
w_valid  out  1  w_out valid
w_ready  in  1  compression core accepts
blk_done  out  1  one-cycle pulse, cycle after W[63] accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high: state=IDLE, window=0, t=0, w_valid=0, blk_ready=0, blk_done=0, taps=0. blk_ready is registered and rises the first cycle after rst deasserts.
- Window r[0..15], r[0] oldest. Taps are always w_16=r[0], w_15=r[1], w_7=r[9], w_2=r[14].
- States:
  - IDLE: blk_ready=1, w_valid=0. On block acceptance: r[i]<=W[i], t<=0, go LOAD_EMIT.
  - LOAD_EMIT: w_valid=1, w_out=r[t], window does not shift. On accept: if t<15, t++; if t==15, t<=16 and go EXT_EMIT directly (taps have been stable for at least 16 cycles).
  - EXT_EMIT: w_valid=1, w_out=ext_w (pass-through). On accept: shift window left, r[15]<=ext_w, then:
    - if t<63: t++ and go EXT_WAIT;
    - if t==63: go IDLE and pulse blk_done next cycle.
  - EXT_WAIT: one bubble cycle, w_valid=0, so ext_w reflects the new taps. Always goes to EXT_EMIT.
- Handshake: once w_valid is high, w_out and w_idx stay stable until accepted. No accept occurs without w_ready.
  - During a stall the taps are held, so ext_w recomputes the same value and stays stable.
- Latency with no stall: first w_valid the cycle after block acceptance. W[0..15] at 1/cycle, W[16] immediately after, W[17..63] one per 2 cycles. Total 111 cycles from first w_valid to final accept.
- Back-to-back: blk_ready rises the cycle after the final accept. blk_done and blk_ready are high in the same cycle.
- flush: has priority over all transitions. Next cycle: IDLE, w_valid=0, t=0, no blk_done. The window is left stale.
- blk_valid outside IDLE is ignored. blk_data is sampled only on the acceptance edge.
- Arithmetic: all modulo 2^32, done in the extension stage. This block does no addition.
- Reset mid-block: immediate return to reset values. No partial blk_done.

Decomposition:
- Package sha_pkg holds: word_t (32-bit); state enum {IDLE, LOAD_EMIT, EXT_EMIT, EXT_WAIT}; constants BLOCK_WORDS=16, SCHED_LEN=64; tap indices 0/1/9/14.
- No sub-module inside this block. The extension stage is instantiated beside it in wrapper sha_msg_sched_top, with taps connected to its inputs and its w to ext_w.
- The bench drives ext_w from a reference model or from the real sha_extension.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1:
  - W[0..15] echoed, W16=0x61626380, W17=0x000F0000.
  - W[18..63] match the golden model.
  - blk_done 1 cycle after the idx-63 accept; 111 cycles first-valid-to-last-accept.
- Random w_ready (50%) on a random block: w_out and w_idx stable while w_valid && !w_ready; sequence identical to the no-stall run.
- Two blocks back-to-back with blk_valid held high: second accepted the cycle after the first's final accept; both schedules correct.
- flush asserted at t=5 and at t=40 (in EXT_WAIT): next cycle IDLE, w_valid=0, no blk_done; a fresh block then schedules correctly.
- rst pulsed asynchronously mid-EXT_EMIT (t=30):
  - All outputs 0 immediately.
  - blk_ready=1 the first cycle after release.
  - blk_valid during LOAD_EMIT is ignored.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 message scheduler.
package sha_pkg;

    localparam int unsigned WORD_BITS   = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned SCHED_LEN   = 64;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [5:0]           idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_EMIT,
        EXT_EMIT,
        EXT_WAIT
    } state_t;

    // Window positions feeding the extension stage
    localparam int unsigned TAP_16 = 0;
    localparam int unsigned TAP_15 = 1;
    localparam int unsigned TAP_7  = 9;
    localparam int unsigned TAP_2  = 14;

    localparam idx_t LOAD_LAST = idx_t'(BLOCK_WORDS - 1);
    localparam idx_t SCHED_LAST = idx_t'(SCHED_LEN - 1);

endpackage

// File: rtl/sha_msg_scheduler_if.sv
// Block-input and schedule-word-output handshakes of the message scheduler.
interface sha_msg_scheduler_if;
    import sha_pkg::*;

    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    word_t        w_out;
    idx_t         w_idx;
    logic         w_valid;
    logic         w_ready;
    logic         blk_done;

    // Scheduler side
    modport slave (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_out, w_idx, w_valid, blk_done
    );

    // Block source / compression-core side
    modport master (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_out, w_idx, w_valid, blk_done
    );

endinterface

// File: rtl/sha_msg_scheduler.sv
// SHA-256 message-schedule sequencer: holds a 16-word sliding window, drives the
// extension-stage taps and streams W[0..63] over a valid/ready interface.
module sha_msg_scheduler
    import sha_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    sha_msg_scheduler_if.slave bus,
    input  logic               flush,
    output logic [WORD_W-1:0]  w_16,
    output logic [WORD_W-1:0]  w_15,
    output logic [WORD_W-1:0]  w_7,
    output logic [WORD_W-1:0]  w_2,
    input  logic [WORD_W-1:0]  ext_w
);

    state_t state_q, state_d;
    idx_t   t_q, t_d;
    word_t  win_q [BLOCK_WORDS];
    logic   blk_ready_q, blk_ready_d;
    logic   blk_done_q, blk_done_d;
    logic   load_en, shift_en, w_acc;

    assign w_acc = bus.w_valid && bus.w_ready;

    // Next-state, index and window-control decode; flush overrides everything
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        blk_done_d = 1'b0;
        if (flush) begin
            state_d = IDLE;
            t_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.blk_valid && blk_ready_q) begin
                        load_en = 1'b1;
                        t_d     = '0;
                        state_d = LOAD_EMIT;
                    end
                end
                LOAD_EMIT: begin
                    if (w_acc) begin
                        t_d = t_q + 6'd1;
                        // Taps were loaded with the block, so W[16] needs no bubble
                        if (t_q == LOAD_LAST) state_d = EXT_EMIT;
                    end
                end
                EXT_EMIT: begin
                    if (w_acc) begin
                        shift_en = 1'b1;
                        if (t_q == SCHED_LAST) begin
                            t_d        = '0;
                            state_d    = IDLE;
                            blk_done_d = 1'b1;
                        end else begin
                            t_d     = t_q + 6'd1;
                            state_d = EXT_WAIT;
                        end
                    end
                end
                EXT_WAIT: state_d = EXT_EMIT;
                default:  state_d = IDLE;
            endcase
        end
        blk_ready_d = (state_d == IDLE);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            blk_ready_q <= 1'b0;
            blk_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            blk_ready_q <= blk_ready_d;
            blk_done_q  <= blk_done_d;
        end
    end

    // Sliding window: parallel load on block accept, shift-in of ext_w on each extended word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) win_q[i] <= '0;
        end else if (load_en) begin
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                win_q[i] <= bus.blk_data[511-32*i -: 32];
            end
        end else if (shift_en) begin
            for (int unsigned i = 0; i < BLOCK_WORDS - 1; i++) win_q[i] <= win_q[i+1];
            win_q[BLOCK_WORDS-1] <= ext_w;
        end
    end

    // Output word select: stored word while loading, extension pass-through afterwards
    always_comb begin
        bus.w_out = '0;
        unique case (state_q)
            LOAD_EMIT: bus.w_out = win_q[t_q[3:0]];
            EXT_EMIT:  bus.w_out = ext_w;
            default:   bus.w_out = '0;
        endcase
    end

    assign bus.w_valid   = (state_q == LOAD_EMIT) || (state_q == EXT_EMIT);
    assign bus.w_idx     = t_q;
    assign bus.blk_ready = blk_ready_q;
    assign bus.blk_done  = blk_done_q;

    assign w_16 = win_q[TAP_16];
    assign w_15 = win_q[TAP_15];
    assign w_7  = win_q[TAP_7];
    assign w_2  = win_q[TAP_2];

endmodule

// File: tb/tb_sha_msg_scheduler.sv
// Scoreboard bench for sha_msg_scheduler with a behavioural extension stage.
module tb_sha_msg_scheduler;
    import sha_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  flush = 1'b0;
    word_t w_16, w_15, w_7, w_2;
    word_t ext_w = '0;

    sha_msg_scheduler_if bus();

    sha_msg_scheduler #(.WORD_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .flush (flush),
        .w_16  (w_16),
        .w_15  (w_15),
        .w_7   (w_7),
        .w_2   (w_2),
        .ext_w (ext_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic word_t s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic word_t s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Registered extension stage
    always @(posedge clk) ext_w <= s1(w_2) + w_7 + s0(w_15) + w_16;

    typedef struct packed {
        logic [5:0] idx;
        word_t      w;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Golden schedule pushed when a block is offered
    task automatic push_block(input logic [511:0] blk);
        word_t w[64];
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) sb.push_back({6'(i), w[i]});
    endtask

    // Monitor
    int         last_acc_edge = -100;
    int         done_edge = -100;
    logic       stall_prev = 1'b0;
    word_t      held_w;
    logic [5:0] held_i;
    word_t      cap[64];

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.blk_done || (cyc == done_edge))
                chk("blk_done", 64'(bus.blk_done), 64'(cyc == done_edge));
            if (bus.w_valid && stall_prev) begin
                chk("stall_w_out", 64'(bus.w_out), 64'(held_w));
                chk("stall_w_idx", 64'(bus.w_idx), 64'(held_i));
            end
            if (bus.w_valid && bus.w_ready && !flush) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got idx %0d w %h, expected none",
                             bus.w_idx, bus.w_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("w_out", 64'(bus.w_out), 64'(e.w));
                    chk("w_idx", 64'(bus.w_idx), 64'(e.idx));
                end
                cap[bus.w_idx] = bus.w_out;
                last_acc_edge = cyc + 1;
                if (bus.w_idx == 6'd63) done_edge = cyc + 1;
            end
            stall_prev = bus.w_valid && !bus.w_ready && !flush;
            held_w = bus.w_out;
            held_i = bus.w_idx;
        end
    end

    // Random backpressure source
    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #2;
        if (rand_ready) bus.w_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [511:0] blk, input bit hold, output int acc_edge);
        int k = 0;
        bus.blk_valid = 1'b1;
        bus.blk_data  = blk;
        push_block(blk);
        while (!bus.blk_ready && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) fail("blk_accept");
        tick();
        acc_edge = cyc;
        if (!hold) bus.blk_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) begin
            fail(name);
            sb.delete();
        end
        repeat (3) tick();
    endtask

    task automatic wait_idx(input logic [5:0] idx, input logic valid, input string name);
        int k = 0;
        while (!(bus.w_valid == valid && bus.w_idx == idx && !bus.blk_ready) && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) fail(name);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
        return b;
    endfunction

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_b;
        int e0;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_valid", 64'(bus.w_valid), 64'd0);
        chk("rst_blk_ready", 64'(bus.blk_ready), 64'd0);
        chk("rst_w_idx", 64'(bus.w_idx), 64'd0);
        chk("rst_w_out", 64'(bus.w_out), 64'd0);
        chk("rst_taps", {w_16, w_15} | {w_7, w_2}, 64'd0);
        rst = 1'b0;
        tick();
        chk("blk_ready_after_rst", 64'(bus.blk_ready), 64'd1);

        // "abc" block, no backpressure
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        send_block(abc, 1'b0, e0);
        chk("first_valid_latency", 64'(bus.w_valid), 64'd1);
        drain("abc_drain");
        chk("abc_w16", 64'(cap[16]), 64'h61626380);
        chk("abc_w17", 64'(cap[17]), 64'h000F0000);
        chk("abc_total_cycles", 64'(last_acc_edge - e0), 64'd111);

        // Random block under 50% backpressure
        rand_ready = 1'b1;
        send_block(rand_block(), 1'b0, e0);
        drain("rand_drain");
        rand_ready = 1'b0;
        bus.w_ready = 1'b1;
        tick();

        // Back-to-back with blk_valid held high
        send_block(rand_block(), 1'b1, e0);
        blk_b = rand_block();
        bus.blk_data = blk_b;
        push_block(blk_b);
        begin
            int k = 0;
            while (!bus.blk_ready && k < 300) begin
                tick();
                k++;
            end
            if (k >= 300) fail("b2b_ready");
            chk("b2b_ready_edge", 64'(cyc), 64'(last_acc_edge));
        end
        tick();
        bus.blk_valid = 1'b0;
        drain("b2b_drain");

        // Flush during LOAD_EMIT at t=5
        send_block(rand_block(), 1'b0, e0);
        wait_idx(6'd5, 1'b1, "wait_t5");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        chk("flush5_w_valid", 64'(bus.w_valid), 64'd0);
        chk("flush5_w_idx", 64'(bus.w_idx), 64'd0);
        chk("flush5_blk_ready", 64'(bus.blk_ready), 64'd1);
        send_block(rand_block(), 1'b0, e0);
        drain("flush5_fresh");

        // Flush in EXT_WAIT at t=40
        send_block(rand_block(), 1'b0, e0);
        wait_idx(6'd40, 1'b0, "wait_t40");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        chk("flush40_w_valid", 64'(bus.w_valid), 64'd0);
        chk("flush40_w_idx", 64'(bus.w_idx), 64'd0);
        chk("flush40_blk_ready", 64'(bus.blk_ready), 64'd1);
        send_block(abc, 1'b0, e0);
        drain("flush40_fresh");

        // Asynchronous reset mid-EXT_EMIT at t=30
        send_block(rand_block(), 1'b0, e0);
        wait_idx(6'd30, 1'b1, "wait_t30");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_w_valid", 64'(bus.w_valid), 64'd0);
        chk("arst_w_idx", 64'(bus.w_idx), 64'd0);
        chk("arst_w_out", 64'(bus.w_out), 64'd0);
        chk("arst_blk_ready", 64'(bus.blk_ready), 64'd0);
        chk("arst_blk_done", 64'(bus.blk_done), 64'd0);
        chk("arst_taps", {w_16, w_15} | {w_7, w_2}, 64'd0);
        sb.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        chk("arst_release_ready", 64'(bus.blk_ready), 64'd1);

        // blk_valid held with different data through LOAD_EMIT must be ignored
        send_block(rand_block(), 1'b1, e0);
        bus.blk_data = rand_block();
        repeat (5) tick();
        bus.blk_valid = 1'b0;
        drain("ignore_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
